// File: rtl/rv32i_types.sv
// Shared front-end types: the fetched instruction-queue entry and its default depth.
package rv32i_types;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO; an accepted entry shows on deq_valid one cycle later.
// Backpressure: enq_ready drops when full (no enqueue even with a same-cycle dequeue); flush empties it.
module inst_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  iq_entry_t                enq_data,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output iq_entry_t                deq_data,
    input  logic                     deq_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("inst_queue: DEPTH must be a power of two and at least 2");
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    iq_entry_t     mem_q [DEPTH];
    iq_entry_t     mem_d [DEPTH];

    logic empty;
    logic full;
    logic do_enq;
    logic do_deq;

    assign empty     = (head_q == tail_q);
    assign full      = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign deq_data  = mem_q[head_q[AW-1:0]];
    assign count     = tail_q - head_q;

    assign do_enq = enq_valid && !full;
    assign do_deq = deq_ready && !empty;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        mem_d  = mem_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (do_enq) begin
                mem_d[tail_q[AW-1:0]] = enq_data;
                tail_d = tail_q + PW'(1);
            end
            if (do_deq) begin
                head_d = head_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage is left unreset; slots are only read once a pointer has covered them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: driver pushes expected entries, a negedge monitor pops and compares.
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic [63:0] enq_data;
    logic        enq_ready;
    logic        deq_valid;
    logic [63:0] deq_data;
    logic        deq_ready;
    logic        flush;
    logic [3:0]  count;

    logic [63:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    inst_queue #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_ready (deq_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] d, input bit accepted);
        enq_valid = 1'b1;
        enq_data  = d;
        if (accepted) exp_q.push_back(d);
    endtask

    // Monitor: a handshake seen at negedge completes on the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && !flush && deq_valid && deq_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL deq_unexpected: got 0x%0h expected no entry", deq_data);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (deq_data !== e) begin
                        failures++;
                        $display("FAIL deq_data: got 0x%0h expected 0x%0h", deq_data, e);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b0; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0; flush = 1'b0;
        #3;
        chk("reset_deq_valid", 64'(deq_valid), 64'd0);
        chk("reset_enq_ready", 64'(enq_ready), 64'd1);
        chk("reset_count", 64'(count), 64'd0);
        #9 rst = 1'b1;
        cyc();

        // Basic latency
        offer(64'h6000000000000013, 1'b1);
        cyc();
        enq_valid = 1'b0;
        chk("lat_deq_valid", 64'(deq_valid), 64'd1);
        chk("lat_deq_data", deq_data, 64'h6000000000000013);
        chk("lat_count", 64'(count), 64'd1);
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;
        chk("lat_drained", 64'(count), 64'd0);

        // Fill to full, rejected 9th offer, then simultaneous op at full
        for (int i = 0; i < 8; i++) begin
            offer({32'h0000_1000 + 32'(i * 4), 32'h0010_0093 + 32'(i)}, 1'b1);
            cyc();
        end
        enq_valid = 1'b0;
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_enq_ready", 64'(enq_ready), 64'd0);
        offer(64'hDEAD_0000_DEAD_0009, 1'b0);
        cyc();
        enq_valid = 1'b0;
        chk("ninth_count", 64'(count), 64'd8);
        offer(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
        deq_ready = 1'b1;
        cyc();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        chk("full_simul_count", 64'(count), 64'd7);
        chk("full_simul_enq_ready", 64'(enq_ready), 64'd1);
        deq_ready = 1'b1;
        repeat (7) cyc();
        deq_ready = 1'b0;
        chk("fill_drain_count", 64'(count), 64'd0);
        chk("fill_drain_deq_valid", 64'(deq_valid), 64'd0);

        // Wrap-around streaming at occupancy 3
        for (int i = 0; i < 3; i++) begin
            offer({32'h0000_2000 + 32'(i * 4), 32'h0000_0013 | (32'(i) << 7)}, 1'b1);
            cyc();
        end
        enq_valid = 1'b0;
        chk("stream_pre_count", 64'(count), 64'd3);
        deq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            offer({32'h0000_3000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i)}, 1'b1);
            cyc();
            chk("stream_count", 64'(count), 64'd3);
        end
        enq_valid = 1'b0;
        repeat (3) cyc();
        deq_ready = 1'b0;
        chk("stream_drain_count", 64'(count), 64'd0);

        // Flush with concurrent enqueue and dequeue
        for (int i = 0; i < 5; i++) begin
            offer({32'h0000_4000 + 32'(i * 4), 32'h0000_0033 + 32'(i)}, 1'b1);
            cyc();
        end
        enq_valid = 1'b0;
        chk("preflush_count", 64'(count), 64'd5);
        flush = 1'b1;
        deq_ready = 1'b1;
        offer(64'hBAD0_0000_BAD0_0000, 1'b0);
        cyc();
        exp_q.delete();
        flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_deq_valid", 64'(deq_valid), 64'd0);
        chk("flush_enq_ready", 64'(enq_ready), 64'd1);
        offer(64'h0000_5000_0000_0067, 1'b1);
        cyc();
        enq_valid = 1'b0;
        chk("postflush_count", 64'(count), 64'd1);
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++) begin
            offer({32'h0000_6000 + 32'(i * 4), 32'h0000_006F + 32'(i)}, 1'b1);
            cyc();
        end
        enq_valid = 1'b0;
        chk("prereset_count", 64'(count), 64'd4);
        #2 rst = 1'b0;
        #1;
        chk("areset_deq_valid", 64'(deq_valid), 64'd0);
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_enq_ready", 64'(enq_ready), 64'd1);
        exp_q.delete();
        rst = 1'b1;
        cyc();
        chk("postreset_empty", 64'(deq_valid), 64'd0);
        offer(64'h0000_7000_0000_00EF, 1'b1);
        cyc();
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;
        cyc();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the entry count; DEPTH SHALL be a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-low (rst=0 resets).
REQ-004 SHALL have port enq_valid, input, 1 bit; the fetch stage offers an entry.
REQ-005 SHALL have port enq_data, input, 64 bits; the fetched entry, {pc[63:32], inst[31:0]}.
REQ-006 SHALL have port enq_ready, output, 1 bit; high when the queue is not full.
REQ-007 SHALL have port deq_valid, output, 1 bit; high when the queue is not empty.
REQ-008 SHALL have port deq_data, output, 64 bits; the head entry, valid while deq_valid is high.
REQ-009 SHALL have port deq_ready, input, 1 bit; decode/dispatch accepts the head.
REQ-010 SHALL have port flush, input, 1 bit; branch mispredict, which discards all entries.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits; the current occupancy.

Function
REQ-012 SHALL be a circular FIFO with head and tail pointers of $clog2(DEPTH)+1 bits, where the MSB is the wrap bit.
REQ-013 SHALL assert empty when head equals tail, and full when the index bits are equal and the wrap bits differ.
REQ-014 SHALL drive enq_ready = !full and deq_valid = !empty, both decoded from registered pointers only, with no combinational path from any input.
REQ-015 SHALL enqueue on a clock edge where enq_valid && enq_ready: write enq_data at tail, tail+1.
REQ-016 SHALL dequeue on a clock edge where deq_valid && deq_ready: head+1.
REQ-017 SHALL drive deq_data combinationally as mem[head index]; deq_data is don't-care when empty.
REQ-018 SHALL make an enqueued entry visible on deq_valid in the cycle after acceptance (latency 1), with no empty bypass.
REQ-019 SHALL allow a simultaneous enqueue and dequeue in one cycle; count is then unchanged.
REQ-020 SHALL NOT accept an enqueue when full, even if a dequeue occurs in the same cycle.
REQ-021 SHALL wrap pointer index bits modulo DEPTH and toggle the wrap bit on wrap.
REQ-022 SHALL give flush priority: on an edge with flush=1, head and tail go to 0 and any enqueue or dequeue in that cycle is ignored.
REQ-023 SHALL make deq_valid low and enq_ready high in the cycle after a flush.
REQ-024 SHALL drive count = tail - head, computed modulo 2^($clog2(DEPTH)+1).
REQ-025 SHALL preserve FIFO order; no entry is dropped or duplicated except by flush or reset.

Reset
REQ-026 SHALL, while rst=0, asynchronously set head=0 and tail=0, giving deq_valid=0, enq_ready=1 and count=0.
REQ-027 SHALL NOT reset the storage array; its contents are unobservable while empty.
REQ-028 SHALL, if reset asserts mid-operation, discard all entries; the queue is empty on the first edge after rst returns high.

Structure
REQ-029 SHALL take the 64-bit entry type from rv32i_types as a packed struct {pc, inst}, named iq_entry_t.
REQ-030 SHALL take the default depth constant IQ_DEPTH from rv32i_types.
REQ-031 SHALL be a single module with no sub-modules; storage is a flop array.

Verification
REQ-032 SHALL cover basic latency: enqueue {0x60000000, 0x00000013} with deq_ready=0 -> next cycle deq_valid=1, deq_data=0x6000000000000013, count=1.
REQ-033 SHALL cover fill: 8 enqueues with deq_ready=0 -> count=8, enq_ready=0; a 9th offer is not accepted; draining returns all 8 in order.
REQ-034 SHALL cover simultaneous operation at full: enq_valid=1 and deq_ready=1 with count=8 -> only the dequeue occurs, count=7, enq_ready=1 the next cycle.
REQ-035 SHALL cover wrap-around: 20 streaming enqueue/dequeue pairs with occupancy held at 3 -> output matches input order; count stays 3.
REQ-036 SHALL cover flush: count=5, then flush=1 with enq_valid=1 and deq_ready=1 -> next cycle count=0, deq_valid=0; the flush-cycle entry is absent.
REQ-037 SHALL cover asynchronous reset: rst=0 pulsed between clock edges with count=4 -> deq_valid=0 and count=0 immediately, before the next edge.
